ram_16x8: RTL
=============

RAM_16X8 -- requirements
Module: ram_16x8

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width in bits; depth is 2**ADDR_W = 16.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port ABUS, input, ADDR_W, read address driven by the memory address register.
REQ-006 SHALL have port CE_n, input, 1, active-low read request.
REQ-007 SHALL have port WBUS, output, DATA_W, registered read data.
REQ-008 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying WBUS.
REQ-009 SHALL have port prog_mode, input, 1, high selects programming mode.
REQ-010 SHALL have port ld_data, input, DATA_W, program byte.
REQ-011 SHALL have port ld_valid, input, 1, ld_data valid.
REQ-012 SHALL have port ld_ready, output, 1, block accepts ld_data.
REQ-013 SHALL have port ld_done, output, 1, all 16 words loaded.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, LOAD and DONE.
REQ-016 SHALL transition IDLE->LOAD when prog_mode=1 and clear the write pointer wptr to 0 on that edge.
REQ-017 SHALL drive ld_ready=1 only in LOAD.
REQ-018 SHALL treat a load transfer as ld_valid=1 and ld_ready=1 at a rising edge: mem[wptr]<=ld_data, wptr<=wptr+1.
REQ-019 SHALL, on the transfer with wptr=15, go to DONE with ld_done=1 from the next cycle; wptr SHALL NOT wrap into a 17th write.
REQ-020 SHALL perform no write when ld_valid=0 in LOAD, leaving wptr unchanged (stall permitted indefinitely).
REQ-021 SHALL, in DONE, hold ld_done=1 and ld_ready=0, ignoring ld_valid.
REQ-022 SHALL transition DONE->IDLE when prog_mode=0, clearing ld_done.
REQ-023 SHALL, if prog_mode falls during LOAD, go to IDLE next edge, keep already-written words, leave ld_done=0, and discard a transfer coinciding with that edge.
REQ-024 SHALL, in IDLE with CE_n=0, register WBUS<=mem[ABUS] and pulse rd_valid=1 on the following cycle (latency 1).
REQ-025 SHALL, with CE_n held low, read every cycle (one word per cycle throughput).
REQ-026 SHALL hold WBUS at its last value and keep rd_valid=0 when CE_n=1 or the state is not IDLE.
REQ-027 SHALL ignore read requests while prog_mode=1, including in the IDLE cycle in which LOAD is entered.
REQ-028 SHALL NOT alter wptr or ld_done on reads.

Reset
REQ-029 SHALL, on rst_n=0, immediately and without waiting for clk: state=IDLE, wptr=0, all 16 words=0, WBUS=0, rd_valid=0, ld_ready=0, ld_done=0, busy=0.
REQ-030 SHALL, if rst_n is asserted mid-LOAD, abandon the load; after release the block SHALL sit in IDLE until prog_mode is sampled high.
REQ-031 SHALL release reset cleanly on the first rising clk edge after rst_n goes high, with no spurious write or rd_valid.

Verification
REQ-032 Bench SHALL cover full load: prog_mode=1, bytes 0x10..0x1F on consecutive cycles -> ld_done=1 after 16 transfers, ld_ready=0; then prog_mode=0, CE_n=0, ABUS=0x5 -> WBUS=0x15 with rd_valid one cycle later.
REQ-033 Bench SHALL cover stall: ld_valid dropped for 3 cycles after word 4 -> no write, wptr stays 4; resume -> word 4 receives the next byte.
REQ-034 Bench SHALL cover abort: prog_mode=0 after 6 words -> IDLE, ld_done=0; words 0-5 readable, words 6-15 still 0.
REQ-035 Bench SHALL cover overflow guard: 20 valid bytes presented -> exactly 16 written, byte 17 onward ignored, mem[0] unchanged.
REQ-036 Bench SHALL cover async reset mid-LOAD: rst_n=0 between clk edges -> busy=0, ld_ready=0 immediately; subsequent reads of all addresses return 0x00.
REQ-037 Bench SHALL cover back-to-back reads: CE_n=0, ABUS 0,1,2,3 on consecutive cycles -> WBUS sequence follows one cycle behind, rd_valid high for 4 cycles.

Source files
------------

// File: rtl/ram_16x8.sv
// 16x8 program-loadable RAM: words stream in through a valid/ready load port while
// prog_mode is high, and are read back one word per cycle with a one-cycle latency.
module ram_16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ABUS,
  input  logic              CE_n,
  output logic [DATA_W-1:0] WBUS,
  output logic              rd_valid,
  input  logic              prog_mode,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              xfer;
  logic              last;
  logic              rd_en;

  // Load handshake: a word moves on a rising edge where ld_valid and ld_ready are
  // both high; ld_valid may stall indefinitely, ld_ready is high exactly in LOAD.
  // A transfer on the edge where prog_mode has dropped is discarded.
  assign xfer  = (state == S_LOAD) && prog_mode && ld_valid;
  assign last  = (wptr == ADDR_W'(DEPTH - 1));
  assign rd_en = (state == S_IDLE) && !prog_mode && !CE_n;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (prog_mode) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!prog_mode) begin
          state_nxt = S_IDLE;
        end else if (xfer && last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: if (!prog_mode) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    busy     = 1'b1;
    case (state)
      S_IDLE: busy = 1'b0;
      S_LOAD: ld_ready = 1'b1;
      S_DONE: ld_done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // The last transfer moves the FSM to DONE, so the pointer wrap is never used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if ((state == S_IDLE) && prog_mode) begin
      wptr <= '0;
    end else if (xfer) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WBUS     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) WBUS <= mem[ABUS];
    end
  end

endmodule
